pwm_multi: RTL

Parametrised multi-channel PWM generator, the successor to the single-channel 100-cycle PWM. One shared period counter drives CHANNELS compare outputs. The period and all duty values are runtime inputs, shadow-loaded at the period boundary so that outputs never glitch mid-period. A one-cycle interrupt marks each period boundary for the control loop that computes the next duties.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_channel.sv | 32 +++
 rtl/pwm_multi.sv | 97 +++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
// The direction type is only referenced when PWM_CENTER_ALIGNED_EN is defined.
package pwm_pkg;

   localparam int PWM_CW     = 10;
   localparam int MIN_PERIOD = 2;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: duty shadow register plus a registered compare against the
// shared period counter. The shadow follows the input only when load is high.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int CW = PWM_CW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          load,
   input  logic [CW-1:0] duty,
   input  logic [CW-1:0] cnt,
   output logic          s
);

   logic [CW-1:0] duty_sh;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         duty_sh <= '0;
         s       <= 1'b0;
      end else begin
         if (load) begin
            duty_sh <= duty;
         end
         // Counter never exceeds Ps-1, so duty >= Ps is a constant high.
         s <= en && (duty_sh > cnt);
      end
   end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter, period shadow, wrap detect and
// interrupt. Define PWM_CENTER_ALIGNED_EN for a triangle (center-aligned) counter.
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int CHANNELS       = 4,
   parameter int CW             = PWM_CW,
   parameter int DEFAULT_PERIOD = 100
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [CW-1:0]          period,
   input  logic [CHANNELS*CW-1:0] d,
   output logic [CHANNELS-1:0]    S,
   output logic                   interrupt
);

   localparam logic [CW-1:0] ONE   = CW'(1);
   localparam logic [CW-1:0] MIN_P = CW'(MIN_PERIOD);

   logic [CW-1:0] cnt;
   logic [CW-1:0] period_sh;
   logic [CW-1:0] period_cl;
   logic [CW-1:0] last;
   logic          wrap;
   logic          load;

   assign period_cl = (period < MIN_P) ? MIN_P : period;
   assign last      = period_sh - ONE;

`ifdef PWM_CENTER_ALIGNED_EN
   dir_t dir;

   // Endpoints repeat once at each turn; the period boundary is down@0.
   assign wrap = en && (dir == DOWN) && (cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst_n || !en) begin
         cnt <= '0;
         dir <= UP;
      end else if (dir == UP) begin
         if (cnt == last) begin
            dir <= DOWN;
         end else begin
            cnt <= cnt + ONE;
         end
      end else begin
         if (cnt == '0) begin
            dir <= UP;
         end else begin
            cnt <= cnt - ONE;
         end
      end
   end
`else
   assign wrap = en && (cnt == last);

   always_ff @(posedge clk) begin
      if (!rst_n || !en || wrap) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + ONE;
      end
   end
`endif

   // While disabled the shadows track the inputs so the first period is current.
   assign load = !en || wrap;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         period_sh <= CW'(DEFAULT_PERIOD);
         interrupt <= 1'b0;
      end else begin
         if (load) begin
            period_sh <= period_cl;
         end
         interrupt <= wrap;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      pwm_channel #(
         .CW (CW)
      ) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .load  (load),
         .duty  (d[i*CW +: CW]),
         .cnt   (cnt),
         .s     (S[i])
      );
   end

endmodule
